// File: rtl/disp_loader.sv
// disp_loader: load sequencer for the six-digit scanned display.
// Snapshots hh:mm:ss on request and pushes six 5-bit digit codes over the
// serial digit/latch interface (hh tens first, ss ones last).
// Optional feature macro: DISP_LOADER_BLINK_EN (blink-mask blanking).
module disp_loader #(
    parameter int          LATCH_W    = 2,
    parameter int          HOLD       = 1,
    parameter logic [4:0]  BLANK_CODE = 5'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] hh_bcd,
    input  logic [7:0] mm_bcd,
    input  logic [7:0] ss_bcd,
    input  logic [5:0] blink_mask,
    input  logic       blink_phase,
    output logic [4:0] digit,
    output logic       latch,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [5:0][4:0] codes_q, codes_d;
    logic [5:0][4:0] new_codes;
    logic [5:0]      blank_pos;
    logic [4:0]      digit_q, digit_d;
    logic            latch_q, latch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    function automatic logic [4:0] bcd_code(input logic [3:0] nib, input logic blank);
        if (blank || nib > 4'd9) begin
            return BLANK_CODE;
        end
        return {1'b0, nib};
    endfunction

`ifdef DISP_LOADER_BLINK_EN
    // Blank positions selected by the mask while the blink phase is active
    assign blank_pos = blink_phase ? blink_mask : '0;
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, blink_phase};
    assign blank_pos    = '0;
`endif

    // Codes indexed by push order; blank_pos is indexed by display position
    assign new_codes[0] = bcd_code(hh_bcd[7:4], blank_pos[5]);
    assign new_codes[1] = bcd_code(hh_bcd[3:0], blank_pos[4]);
    assign new_codes[2] = bcd_code(mm_bcd[7:4], blank_pos[3]);
    assign new_codes[3] = bcd_code(mm_bcd[3:0], blank_pos[2]);
    assign new_codes[4] = bcd_code(ss_bcd[7:4], blank_pos[1]);
    assign new_codes[5] = bcd_code(ss_bcd[3:0], blank_pos[0]);

    // Next-state, snapshot, queued-request and registered-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        codes_d = codes_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req || pend_q) begin
                    state_d = ST_SETUP;
                    idx_d   = '0;
                    codes_d = new_codes;
                    pend_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d = ST_HIGH;
                cnt_d   = '0;
            end
            ST_HIGH: begin
                if (cnt_q == CNT_W'(LATCH_W - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD - 1)) begin
                    cnt_d = '0;
                    if (idx_q == 3'd5) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && req) begin
            pend_d = 1'b1;
        end

        // Outputs are decoded from the next state so they register with it
        digit_d = digit_q;
        if (state_d == ST_SETUP) begin
            digit_d = codes_d[idx_d];
        end
        latch_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            codes_q <= '0;
            digit_q <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            codes_q <= codes_d;
            digit_q <= digit_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign digit = digit_q;
    assign latch = latch_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_disp_loader.sv
// tb_disp_loader: self-checking bench for disp_loader (default parameters
// plus a LATCH_W=3 / HOLD=2 instance) with a behavioural display model.
module tb_disp_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       req2;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [5:0] bm;
    logic       bp;

    logic [4:0] digit1, digit2;
    logic       latch1, latch2, busy1, busy2, done1, done2;

    logic       sel = 1'b0;
    logic [4:0] m_digit;
    logic       m_latch, m_busy, m_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    disp_loader dut (
        .clk(clk), .rst(rst), .req(req),
        .hh_bcd(hh), .mm_bcd(mm), .ss_bcd(ss),
        .blink_mask(bm), .blink_phase(bp),
        .digit(digit1), .latch(latch1), .busy(busy1), .done(done1)
    );

    disp_loader #(.LATCH_W(3), .HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2),
        .hh_bcd(hh), .mm_bcd(mm), .ss_bcd(ss),
        .blink_mask(bm), .blink_phase(bp),
        .digit(digit2), .latch(latch2), .busy(busy2), .done(done2)
    );

    assign m_digit = sel ? digit2 : digit1;
    assign m_latch = sel ? latch2 : latch1;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_done  = sel ? done2  : done1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected code at display position pos (0 = ss ones ... 5 = hh tens)
    function automatic logic [4:0] ref_code(input int pos, input logic [7:0] h, input logic [7:0] m,
                                            input logic [7:0] s, input logic [5:0] b, input logic p);
        int vals[6];
        int v;
        logic blk;
        vals[0] = int'(s) % 16;
        vals[1] = int'(s) / 16;
        vals[2] = int'(m) % 16;
        vals[3] = int'(m) / 16;
        vals[4] = int'(h) % 16;
        vals[5] = int'(h) / 16;
        v   = vals[pos];
        blk = p & b[pos];
`ifndef DISP_LOADER_BLINK_EN
        blk = 1'b0;
`endif
        if (blk || v > 9) return 5'd16;
        return 5'(v);
    endfunction

    task automatic start_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic [5:0] b, input logic p);
        @(negedge clk);
        hh = h; mm = m; ss = s; bm = b; bp = p;
        if (sel) req2 = 1'b1;
        else     req  = 1'b1;
    endtask

    // Watch one load starting at the cycle after acceptance; model the display shift register
    task automatic observe(input string tag, input int lw, input int hd,
                           input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic [5:0] b, input logic p, input bit collapse);
        int         per;
        logic [4:0] disp [6];
        int         ncap, done_at, done_cnt, busy_cnt, high_run, hold_left;
        bit         timing_ok;
        logic       prev_latch;
        logic [4:0] prev_digit, last_cap;
        per = 6 * (1 + lw + hd);
        ncap = 0; done_at = -1; done_cnt = 0; busy_cnt = 0;
        high_run = 0; hold_left = 0; timing_ok = 1'b1;
        prev_latch = 1'b0; prev_digit = '0; last_cap = '0;
        for (int i = 0; i < 6; i++) disp[i] = '0;
        for (int c = 0; c <= per + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({tag, "/accept_busy"}, 32'(m_busy), 32'd1);
                check({tag, "/first_digit"}, 32'(m_digit), 32'(ref_code(5, h, m, s, b, p)));
            end
            if (m_busy) busy_cnt++;
            if (m_done) begin done_cnt++; done_at = c; end
            if (m_latch) begin
                if (m_digit !== prev_digit) timing_ok = 1'b0;
                if (!prev_latch && hold_left > 0) timing_ok = 1'b0;
                high_run++;
            end else if (prev_latch) begin
                if (high_run != lw) timing_ok = 1'b0;
                if (m_digit !== prev_digit) timing_ok = 1'b0;
                high_run  = 0;
                last_cap  = prev_digit;
                hold_left = hd - 1;
                for (int i = 5; i > 0; i--) disp[i] = disp[i-1];
                disp[0] = prev_digit;
                ncap++;
            end else if (hold_left > 0) begin
                if (m_digit !== last_cap) timing_ok = 1'b0;
                hold_left--;
            end
            if (collapse && (c == 3 || c == 8 || c == 15)) req = 1'b1;
            else begin req = 1'b0; req2 = 1'b0; end
            if (collapse && c == 6) ss = 8'h59;
            prev_latch = m_latch;
            prev_digit = m_digit;
        end
        check({tag, "/done_cycle"}, 32'(done_at), 32'(per));
        check({tag, "/done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(per + 1));
        check({tag, "/latch_pulses"}, 32'(ncap), 32'd6);
        check({tag, "/setup_hold"}, 32'(timing_ok), 32'd1);
        for (int pos = 0; pos < 6; pos++)
            check($sformatf("%s/pos%0d", tag, pos), 32'(disp[pos]), 32'(ref_code(pos, h, m, s, b, p)));
    endtask

    initial begin
        bit         quiet;
        int         busy_seen;
        logic [7:0] rh, rm, rs;
        logic [5:0] rb;
        logic       rp;

        rst = 1'b1; req = 1'b0; req2 = 1'b0;
        hh = '0; mm = '0; ss = '0; bm = '0; bp = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/digit", 32'(digit1), 32'd0);
        check("reset/latch", 32'(latch1), 32'd0);
        check("reset/busy",  32'(busy1),  32'd0);
        check("reset/done",  32'(done1),  32'd0);
        check("reset/busy2", 32'(busy2),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single load
        start_load(8'h12, 8'h34, 8'h56, 6'b0, 1'b0);
        observe("single", 2, 1, 8'h12, 8'h34, 8'h56, 6'b0, 1'b0, 1'b0);

        // Invalid BCD in mm tens
        start_load(8'h12, 8'hA7, 8'h56, 6'b0, 1'b0);
        observe("invalid", 2, 1, 8'h12, 8'hA7, 8'h56, 6'b0, 1'b0, 1'b0);

        // Blink mask on ss positions
        start_load(8'h10, 8'h20, 8'h42, 6'b000011, 1'b1);
        observe("blink", 2, 1, 8'h10, 8'h20, 8'h42, 6'b000011, 1'b1, 1'b0);

        // Three requests during a load collapse into one follow-up using ss=59
        start_load(8'h12, 8'h34, 8'h56, 6'b0, 1'b0);
        observe("collapse_a", 2, 1, 8'h12, 8'h34, 8'h56, 6'b0, 1'b0, 1'b1);
        observe("collapse_b", 2, 1, 8'h12, 8'h34, 8'h59, 6'b0, 1'b0, 1'b0);
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy1) busy_seen++;
        end
        check("collapse/no_third_load", 32'(busy_seen), 32'd0);

        // Randomized loads
        for (int n = 0; n < 6; n++) begin
            rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom);
            rb = 6'($urandom); rp = 1'($urandom);
            start_load(rh, rm, rs, rb, rp);
            observe($sformatf("rand%0d", n), 2, 1, rh, rm, rs, rb, rp, 1'b0);
        end

        // Non-default timing parameters
        sel = 1'b1;
        start_load(8'h23, 8'h59, 8'h07, 6'b0, 1'b0);
        observe("params", 3, 2, 8'h23, 8'h59, 8'h07, 6'b0, 1'b0, 1'b0);
        rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom);
        rb = 6'($urandom); rp = 1'($urandom);
        start_load(rh, rm, rs, rb, rp);
        observe("params_rand", 3, 2, rh, rm, rs, rb, rp, 1'b0);
        sel = 1'b0;

        // Reset asserted mid-HIGH
        start_load(8'h12, 8'h34, 8'h56, 6'b0, 1'b0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_mid/latch_before", 32'(latch1), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid/latch", 32'(latch1), 32'd0);
        check("rst_mid/busy",  32'(busy1),  32'd0);
        check("rst_mid/done",  32'(done1),  32'd0);
        check("rst_mid/digit", 32'(digit1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (latch1 || busy1) quiet = 1'b0;
        end
        check("rst_mid/no_latch_100", 32'(quiet), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
